cpu_mem: RTL

Pipeline MEM stage, directly downstream of the EX stage. It consumes EX's latched outputs (PC, instruction, ALU result, store data, writeback tag and data) and performs byte, halfword and word loads and stores on a request/acknowledge data-memory bus. It stalls the upstream pipeline while an access is outstanding. It latches the WB-bound result, which is also the `reg_write_data_mem` forwarding source for EX.

---
 rtl/cpu_mem_if.sv | 31 +++
 rtl/cpu_mem.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_if.sv
// Request/acknowledge data-memory bus between the MEM pipeline stage (master)
// and the data memory (slave).
interface cpu_mem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/cpu_mem.sv
// Pipeline MEM stage: byte/half/word loads and stores over a req/ack bus,
// upstream stall while an access is outstanding, and the WB-bound result latch.
module cpu_mem #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      current_pc_ex,
    input  logic [31:0]      ins_ex,
    input  logic             mem_read_ex,
    input  logic             mem_write_ex,
    input  logic [1:0]       mem_size_ex,
    input  logic             mem_sign_ex,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      reg_read2_data_ex,
    input  logic             reg_write_en,
    input  logic [4:0]       reg_write_num,
    input  logic [31:0]      reg_write_data,
    cpu_mem_if.master        dmem,
    output logic             stall,
    output logic [31:0]      current_pc_mem,
    output logic [31:0]      ins_mem,
    output logic             reg_write_en_mem,
    output logic [4:0]       reg_write_num_mem,
    output logic [31:0]      reg_write_data_mem,
    output logic             mem_exc,
    output logic [1:0]       mem_exc_code,
    output logic [31:0]      mem_badvaddr
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  EXC_MISALIGN = 2'b01;
    localparam logic [1:0]  EXC_TIMEOUT  = 2'b10;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    // Access captured on entry to BUSY; the bus is driven only from these.
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        wen_q, wen_d;
    logic [4:0]  wnum_q, wnum_d;

    logic [31:0] pc_mem_q, pc_mem_d;
    logic [31:0] ins_mem_q, ins_mem_d;
    logic        wen_mem_q, wen_mem_d;
    logic [4:0]  wnum_mem_q, wnum_mem_d;
    logic [31:0] wdata_mem_q, wdata_mem_d;
    logic        exc_q, exc_d;
    logic [1:0]  exc_code_q, exc_code_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic        access;
    logic        aligned;
    logic        ack_done;
    logic        timeout_hit;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    always_comb begin
        access = mem_read_ex | mem_write_ex;

        unique case (mem_size_ex)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~alu_result[0];
            default: aligned = (alu_result[1:0] == 2'b00);
        endcase

        unique case (mem_size_ex)
            2'b00: begin
                store_be    = 4'b0001 << alu_result[1:0];
                store_wdata = {4{reg_read2_data_ex[7:0]}};
            end
            2'b01: begin
                store_be    = alu_result[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{reg_read2_data_ex[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = reg_read2_data_ex;
            end
        endcase

        // Reads always fetch the whole word; the lane is picked on return.
        if (!mem_write_ex) begin
            store_be    = 4'b1111;
            store_wdata = 32'h0;
        end
    end

    always_comb begin
        load_byte = dmem.dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        load_half = addr_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

        unique case (size_q)
            2'b00:   load_data = {{24{sign_q & load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{sign_q & load_half[15]}}, load_half};
            default: load_data = dmem.dmem_rdata;
        endcase

        ack_done    = (state_q == BUSY) && dmem.dmem_ack;
        timeout_hit = (state_q == BUSY) && !dmem.dmem_ack && (cnt_q == TIMEOUT_LAST);
    end

    // Next-state logic; an ack on the final counted cycle still completes normally.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 16'h0;
                if (access && aligned) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ack_done || timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = 16'h0;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'h0;
            end
        endcase
    end

    always_comb begin
        stall           = 1'b0;
        dmem.dmem_req   = (state_q == BUSY);
        dmem.dmem_we    = we_q;
        dmem.dmem_addr  = addr_q[31:2];
        dmem.dmem_be    = be_q;
        dmem.dmem_wdata = wdata_q;

        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        wen_d   = wen_q;
        wnum_d  = wnum_q;

        pc_mem_d    = pc_mem_q;
        ins_mem_d   = ins_mem_q;
        wen_mem_d   = wen_mem_q;
        wnum_mem_d  = wnum_mem_q;
        wdata_mem_d = wdata_mem_q;
        exc_d       = 1'b0;
        exc_code_d  = exc_code_q;
        badvaddr_d  = badvaddr_q;

        unique case (state_q)
            IDLE: begin
                if (!access) begin
                    pc_mem_d    = current_pc_ex;
                    ins_mem_d   = ins_ex;
                    wen_mem_d   = reg_write_en;
                    wnum_mem_d  = reg_write_num;
                    wdata_mem_d = reg_write_data;
                end else if (!aligned) begin
                    pc_mem_d    = current_pc_ex;
                    ins_mem_d   = ins_ex;
                    wen_mem_d   = 1'b0;
                    wnum_mem_d  = 5'd0;
                    wdata_mem_d = 32'h0;
                    exc_d       = 1'b1;
                    exc_code_d  = EXC_MISALIGN;
                    badvaddr_d  = alu_result;
                end else begin
                    stall       = 1'b1;
                    addr_d      = alu_result;
                    be_d        = store_be;
                    wdata_d     = store_wdata;
                    we_d        = mem_write_ex;
                    size_d      = mem_size_ex;
                    sign_d      = mem_sign_ex;
                    wen_d       = reg_write_en;
                    wnum_d      = reg_write_num;
                    pc_mem_d    = current_pc_ex;
                    ins_mem_d   = 32'h0;
                    wen_mem_d   = 1'b0;
                    wnum_mem_d  = 5'd0;
                    wdata_mem_d = 32'h0;
                end
            end
            BUSY: begin
                stall = !dmem.dmem_ack && !timeout_hit;
                if (ack_done) begin
                    pc_mem_d    = current_pc_ex;
                    ins_mem_d   = ins_ex;
                    wen_mem_d   = wen_q;
                    wnum_mem_d  = wnum_q;
                    wdata_mem_d = we_q ? reg_write_data : load_data;
                end else if (timeout_hit) begin
                    pc_mem_d    = current_pc_ex;
                    ins_mem_d   = 32'h0;
                    wen_mem_d   = 1'b0;
                    wnum_mem_d  = 5'd0;
                    wdata_mem_d = 32'h0;
                    exc_d       = 1'b1;
                    exc_code_d  = EXC_TIMEOUT;
                    badvaddr_d  = addr_q;
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Synchronous clear also abandons an in-flight access without writeback.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= 16'h0;
            addr_q      <= 32'h0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sign_q      <= 1'b0;
            wen_q       <= 1'b0;
            wnum_q      <= 5'd0;
            pc_mem_q    <= 32'h0;
            ins_mem_q   <= 32'h0;
            wen_mem_q   <= 1'b0;
            wnum_mem_q  <= 5'd0;
            wdata_mem_q <= 32'h0;
            exc_q       <= 1'b0;
            exc_code_q  <= 2'b00;
            badvaddr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            wen_q       <= wen_d;
            wnum_q      <= wnum_d;
            pc_mem_q    <= pc_mem_d;
            ins_mem_q   <= ins_mem_d;
            wen_mem_q   <= wen_mem_d;
            wnum_mem_q  <= wnum_mem_d;
            wdata_mem_q <= wdata_mem_d;
            exc_q       <= exc_d;
            exc_code_q  <= exc_code_d;
            badvaddr_q  <= badvaddr_d;
        end
    end

    assign current_pc_mem     = pc_mem_q;
    assign ins_mem            = ins_mem_q;
    assign reg_write_en_mem   = wen_mem_q;
    assign reg_write_num_mem  = wnum_mem_q;
    assign reg_write_data_mem = wdata_mem_q;
    assign mem_exc            = exc_q;
    assign mem_exc_code       = exc_code_q;
    assign mem_badvaddr       = badvaddr_q;

endmodule
